// File: rtl/recolector_carriles.sv
// recolector_carriles: per-lane deskew FIFOs feeding a round-robin un-striper (lane 0,1,2,3,0,...).
// Define RECOLECTOR_BYTE_COUNT_EN to add a 16-bit wrapping count of emitted bytes (byte_count).

module recolector_carril #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AF_TH      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  overflow
);
    localparam int          PW    = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] AF    = (PW+1)'(AF_TH);
    localparam logic [PW:0] ONE   = (PW+1)'(1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count, count_next;
    logic                  full, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees a slot, so a write into a full lane still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + ONE;
        else if (do_pop && !do_push)
            count_next = count - ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count       <= count_next;
            almost_full <= (count_next >= AF);
            if (push && !do_push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data;
    end
endmodule

module recolector_carriles #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AF_TH      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    input  logic                  valid_in0,
    input  logic                  valid_in1,
    input  logic                  valid_in2,
    input  logic                  valid_in3,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  active_out,
    output logic [3:0]            almost_full,
    output logic [3:0]            overflow
`ifdef RECOLECTOR_BYTE_COUNT_EN
    ,
    output logic [15:0]           byte_count
`endif
);
    localparam int NUM_LANES = 4;

    typedef enum logic {ESPERA, ACTIVO} estado_t;

    estado_t                              state, state_next;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_data, lane_head;
    logic [NUM_LANES-1:0]                 lane_valid, lane_empty, lane_pop;
    logic [1:0]                           rd_lane, rd_lane_next;
    logic [DATA_WIDTH-1:0]                data_next;
    logic                                 valid_next;

    assign lane_data  = {data_in3, data_in2, data_in1, data_in0};
    assign lane_valid = {valid_in3, valid_in2, valid_in1, valid_in0};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_carril
        recolector_carril #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .AF_TH      (AF_TH)
        ) u_carril (
            .clk         (clk),
            .reset       (reset),
            .data        (lane_data[i]),
            .push        (lane_valid[i]),
            .pop         (lane_pop[i]),
            .head        (lane_head[i]),
            .empty       (lane_empty[i]),
            .almost_full (almost_full[i]),
            .overflow    (overflow[i])
        );
    end

    // Strict round-robin: an empty current lane stalls rather than skipping, preserving byte order.
    always_comb begin
        state_next   = state;
        rd_lane_next = rd_lane;
        lane_pop     = '0;
        data_next    = data_out;
        valid_next   = 1'b0;
        case (state)
            ESPERA: begin
                rd_lane_next = 2'd0;
                if (lane_empty == '0)
                    state_next = ACTIVO;
            end
            ACTIVO: begin
                if (rd_lane == 2'd0 && &lane_empty) begin
                    state_next = ESPERA;
                end else if (!lane_empty[rd_lane]) begin
                    lane_pop[rd_lane] = 1'b1;
                    data_next         = lane_head[rd_lane];
                    valid_next        = 1'b1;
                    rd_lane_next      = rd_lane + 2'd1;
                end
            end
            default: state_next = ESPERA;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ESPERA;
            rd_lane    <= 2'd0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            active_out <= 1'b0;
        end else begin
            state      <= state_next;
            rd_lane    <= rd_lane_next;
            data_out   <= data_next;
            valid_out  <= valid_next;
            active_out <= (state_next == ACTIVO);
        end
    end

`ifdef RECOLECTOR_BYTE_COUNT_EN
    // Running total across bursts; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            byte_count <= 16'h0000;
        else if (valid_next)
            byte_count <= byte_count + 16'h0001;
    end
`endif
endmodule

// File: tb/tb_recolector_carriles.sv
// Bench for recolector_carriles: directed plan scenarios plus randomized skewed bursts,
// with a queue scoreboard holding the expected un-striped byte order.

module tb_recolector_carriles;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in0, data_in1, data_in2, data_in3;
    logic          valid_in0, valid_in1, valid_in2, valid_in3;
    logic [DW-1:0] data_out;
    logic          valid_out, active_out;
    logic [3:0]    almost_full, overflow;
`ifdef RECOLECTOR_BYTE_COUNT_EN
    logic [15:0]   byte_count;
    logic [15:0]   n_out = 16'h0000;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;

    always #5 clk = ~clk;

    recolector_carriles dut (
        .clk         (clk),
        .reset       (reset),
        .data_in0    (data_in0),
        .data_in1    (data_in1),
        .data_in2    (data_in2),
        .data_in3    (data_in3),
        .valid_in0   (valid_in0),
        .valid_in1   (valid_in1),
        .valid_in2   (valid_in2),
        .valid_in3   (valid_in3),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active_out  (active_out),
        .almost_full (almost_full),
        .overflow    (overflow)
`ifdef RECOLECTOR_BYTE_COUNT_EN
        ,
        .byte_count  (byte_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic set_lanes(input logic [3:0] v, input logic [3:0][DW-1:0] d);
        {valid_in3, valid_in2, valid_in1, valid_in0} = v;
        data_in0 = d[0];
        data_in1 = d[1];
        data_in2 = d[2];
        data_in3 = d[3];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [3:0][DW-1:0] d);
        for (int l = 0; l < 4; l++) exp_q.push_back(d[l]);
    endtask

    // Asserted between edges; everything must clear at once.
    task automatic do_reset(input string name);
        set_lanes(4'h0, '0);
        #2 reset = 1'b0;
        #1;
        check({name, "_data_out"},    32'(data_out),    32'd0);
        check({name, "_valid_out"},   32'(valid_out),   32'd0);
        check({name, "_active_out"},  32'(active_out),  32'd0);
        check({name, "_almost_full"}, 32'(almost_full), 32'd0);
        check({name, "_overflow"},    32'(overflow),    32'd0);
        exp_q.delete();
`ifdef RECOLECTOR_BYTE_COUNT_EN
        n_out = 16'h0000;
`endif
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || active_out) && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()) + 32'(active_out), 32'd0);
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got %0h, want no output", data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(mon_exp));
            end
        end
`ifdef RECOLECTOR_BYTE_COUNT_EN
        if (reset) begin
            if (valid_out) n_out = n_out + 16'h0001;
            check("byte_count", 32'(byte_count), 32'(n_out));
        end
`endif
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]         pat;
        logic [3:0]          v;
        logic [3:0][DW-1:0]  d;
        logic [DW-1:0]       m [4][4];
        int                  dly [4];
        int                  wr [4];
        int                  rows, cyc;
        logic                busy;

        reset = 1'b1;
        set_lanes(4'h0, '0);
        @(posedge clk);
        do_reset("rst0");

        // Aligned burst: cycle-exact latency and burst end.
        push_row({8'h13, 8'h12, 8'h11, 8'h10});
        push_row({8'h23, 8'h22, 8'h21, 8'h20});
        set_lanes(4'hF, {8'h13, 8'h12, 8'h11, 8'h10}); tick();
        check("aligned_active_n0", 32'(active_out), 32'd0);
        set_lanes(4'hF, {8'h23, 8'h22, 8'h21, 8'h20}); tick();
        set_lanes(4'h0, '0);
        check("aligned_active_n1", 32'(active_out), 32'd1);
        check("aligned_valid_n1",  32'(valid_out),  32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("aligned_valid", 32'(valid_out), 32'd1);
        end
        tick();
        check("aligned_end_valid",  32'(valid_out),  32'd0);
        check("aligned_end_active", 32'(active_out), 32'd0);
        check("aligned_end_queue",  32'(exp_q.size()), 32'd0);

        // Lane 3 skewed two cycles behind.
        push_row({8'h13, 8'h12, 8'h11, 8'h10});
        push_row({8'h23, 8'h22, 8'h21, 8'h20});
        set_lanes(4'b0111, {8'h00, 8'h12, 8'h11, 8'h10}); tick();
        set_lanes(4'b0111, {8'h00, 8'h22, 8'h21, 8'h20}); tick();
        set_lanes(4'b1000, {8'h13, 8'h00, 8'h00, 8'h00}); tick();
        check("skew_active_early", 32'(active_out), 32'd0);
        check("skew_almost_full",  32'(almost_full), 32'd0);
        set_lanes(4'b1000, {8'h23, 8'h00, 8'h00, 8'h00}); tick();
        set_lanes(4'h0, '0);
        check("skew_active", 32'(active_out), 32'd1);
        drain("skew_drain");
        check("skew_overflow", 32'(overflow), 32'd0);

        // Lane 2's second byte lands at edge S+10: three stall cycles after 8'h21.
        push_row({8'h13, 8'h12, 8'h11, 8'h10});
        push_row({8'h23, 8'h22, 8'h21, 8'h20});
        pat = 16'b0001_1000_1111_1100;
        set_lanes(4'hF, {8'h13, 8'h12, 8'h11, 8'h10}); tick();
        set_lanes(4'b1011, {8'h23, 8'h00, 8'h21, 8'h20}); tick();
        set_lanes(4'h0, '0);
        for (int t = 2; t <= 13; t++) begin
            if (t == 10) set_lanes(4'b0100, {8'h00, 8'h22, 8'h00, 8'h00});
            tick();
            set_lanes(4'h0, '0);
            check("starve_valid", 32'(valid_out), 32'(pat[t]));
        end
        check("starve_active_end", 32'(active_out), 32'd0);
        check("starve_queue", 32'(exp_q.size()), 32'd0);

        // Overflow: lane 0 only, six writes.
        do_reset("rst_ovf");
        for (int k = 1; k <= 6; k++) begin
            set_lanes(4'b0001, {8'h00, 8'h00, 8'h00, 8'(8'hA0 + k)});
            tick();
            check("ovf_almost_full", 32'(almost_full), 32'((k >= 3) ? 1 : 0));
            check("ovf_overflow",    32'(overflow),    32'((k >= 5) ? 1 : 0));
        end
        set_lanes(4'h0, '0);
        repeat (3) tick();
        check("ovf_no_active", 32'(active_out), 32'd0);
        check("ovf_sticky",    32'(overflow),   32'd1);

        // Reset while 8'h12 is on the output.
        do_reset("rst_pre");
        push_row({8'h13, 8'h12, 8'h11, 8'h10});
        push_row({8'h23, 8'h22, 8'h21, 8'h20});
        set_lanes(4'hF, {8'h13, 8'h12, 8'h11, 8'h10}); tick();
        set_lanes(4'hF, {8'h23, 8'h22, 8'h21, 8'h20}); tick();
        set_lanes(4'h0, '0);
        repeat (3) tick();
        check("midrst_byte", 32'(data_out), 32'h12);
        do_reset("midrst");
        for (int k = 0; k < 6; k++) begin
            tick();
            check("midrst_idle_valid", 32'(valid_out), 32'd0);
        end

        // Randomized bursts: each lane delayed 0..3 cycles with random gaps; at most
        // FIFO_DEPTH rows per burst so no lane can overflow.
        for (int b = 0; b < 30; b++) begin
            rows = int'($urandom_range(1, 4));
            for (int r = 0; r < rows; r++) begin
                for (int l = 0; l < 4; l++) begin
                    m[r][l] = 8'($urandom);
                    exp_q.push_back(m[r][l]);
                end
            end
            for (int l = 0; l < 4; l++) begin
                dly[l] = int'($urandom_range(0, 3));
                wr[l]  = 0;
            end
            cyc  = 0;
            busy = 1'b1;
            while (busy && cyc < 100) begin
                v = 4'h0;
                d = '0;
                for (int l = 0; l < 4; l++) begin
                    if (cyc >= dly[l] && wr[l] < rows && $urandom_range(0, 3) != 0) begin
                        v[l] = 1'b1;
                        d[l] = m[wr[l]][l];
                        wr[l]++;
                    end
                end
                set_lanes(v, d);
                tick();
                cyc++;
                busy = 1'b0;
                for (int l = 0; l < 4; l++) if (wr[l] < rows) busy = 1'b1;
            end
            set_lanes(4'h0, '0);
            drain("rand_drain");
            check("rand_overflow", 32'(overflow), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
